mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the CPU's instruction-fetch port and data port.
//  Registers the winning request, holds it on the memory bus until memReady, then returns read data
//  with a one-cycle valid pulse. A watchdog aborts memory accesses that never complete.
//  Sits between the PC/fetch logic plus load/store datapath and the shared memory model.
// PARAMETERS
//  ADDR_W      32   address width, all ports
//  DATA_W      32   data width, all ports
//  D_PRIORITY  1    1: data port wins simultaneous requests; 0: fetch wins
//  TIMEOUT     16   max cycles in BUSY without memReady before abort (>=2)
// PORTS
//  clk       in   1       clock, rising edge
//  rst_n     in   1       asynchronous reset, active low
//  ifReq     in   1       fetch request; hold until ifValid
//  ifAddr    in   ADDR_W  fetch address
//  ifValid   out  1       one-cycle pulse: ifRdata valid
//  ifRdata   out  DATA_W  fetched instruction
//  dReq      in   1       data request; hold until dValid
//  dWrEn     in   1       1 = store, 0 = load
//  dAddr     in   ADDR_W  data address
//  dWdata    in   DATA_W  store data
//  dValid    out  1       one-cycle pulse: load data valid / store acknowledged
//  dRdata    out  DATA_W  load data (0 for stores)
//  memReq    out  1       memory access strobe
//  memWrEn   out  1       memory write enable
//  memAddr   out  ADDR_W  memory address
//  memWdata  out  DATA_W  memory write data
//  memRdata  in   DATA_W  memory read data, sampled with memReady
//  memReady  in   1       memory completion; may go high in the first memReq cycle
//  err       out  1       one-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset: clk and rst_n only. rst_n low asynchronously forces state IDLE, clears the timer,
//   and drives every output to 0 (memReq drops immediately; any in-flight access is abandoned).
//  FSM: IDLE, BUSY, RESP.
//   IDLE: arbitrate between ifReq and dReq. Both high: winner per D_PRIORITY. One high: that port wins.
//    On a grant, latch owner, addr, wdata and wrEn (wrEn = 0 for fetch), then go to BUSY.
//   BUSY: memReq=1; memAddr/memWdata/memWrEn driven from latches, stable the whole state.
//    Timer counts up from 0 on BUSY entry.
//    memReady=1: latch memRdata (0 if write) into the owner's rdata register, then go to RESP.
//    Timer reaches TIMEOUT-1 with memReady=0: latch rdata = 32'hDEADBEEF, set err_q, then go to RESP.
//   RESP: the owner's valid=1 for exactly this cycle. err=1 this cycle if aborted.
//    No arbitration in RESP. Then go to IDLE.
//  Timing: requester must drop req, or present a new request, in the cycle after valid.
//   A req seen in IDLE is always a new transaction.
//  Latency: req high at edge N -> memReq from N+1 -> with memReady at N+1, valid during N+2.
//   Minimum 3 cycles per transaction. Back-to-back throughput is 1 transaction per 3 cycles.
//  Rdata registers hold their value until the next completion for that port. Valid does not gate them.
//  Boundaries:
//   memReady in IDLE/RESP: ignored.
//   Req changes during BUSY: ignored, because of the latches.
//   Both reqs held continuously with D_PRIORITY=1: data served every time; fetch starves by design.
//   The CPU never holds dReq across fetches.
//   Timeout on the exact cycle memReady arrives: memReady wins, no err.
//  Widths: the timer is $clog2(TIMEOUT)+1 bits and never wraps; it is cleared on BUSY entry.
// STRUCTURE
//  Shared include cpu_defs.vh: state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_RESP=2'd2;
//   ABORT_DATA=32'hDEADBEEF; OWNER_IF=1'b0, OWNER_D=1'b1.
//  One sub-module, busy_timer: clear, enable, TIMEOUT parameter, expired output.
//  Everything else is flat in this module.
// TESTING
//  1 Reset: rst_n low mid-BUSY -> memReq, ifValid, dValid, err are 0 within the same cycle; state IDLE after release.
//  2 ifReq=1, ifAddr=0x40; memReady=1 immediately with memRdata=0x2002000A
//    -> memAddr=0x40, memWrEn=0; ifValid pulses 2 cycles after req; ifRdata=0x2002000A.
//  3 ifReq and dReq both high, D_PRIORITY=1, dWrEn=1, dAddr=0x100, dWdata=0x55
//    -> memWrEn=1, memWdata=0x55 first; dValid with dRdata=0; then fetch is granted after RESP->IDLE.
//  4 memReady delayed 5 cycles on a load -> memReq and memAddr stable for all 5 cycles; single dValid; no err.
//  5 memReady never asserted, TIMEOUT=16 -> abort after 16 BUSY cycles; dValid=1, err=1, dRdata=0xDEADBEEF; then IDLE.
//  6 memReady pulsed in IDLE and RESP; ifAddr changed mid-BUSY -> no spurious valid; memAddr keeps the latched value.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Replaces the old cpu_defs.vh include; encodings are unchanged.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_e;

    localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/busy_timer.sv
// Watchdog counter for the arbiter's BUSY state.
// Saturates at TIMEOUT-1 so it never wraps; clear takes priority over enable.
module busy_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT) + 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one single-ported memory,
// holding the granted access until memReady or a watchdog abort.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter bit          D_PRIORITY = 1'b1,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic              ifValid,
    output logic [DATA_W-1:0] ifRdata,
    input  logic              dReq,
    input  logic              dWrEn,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    output logic              dValid,
    output logic [DATA_W-1:0] dRdata,
    output logic              memReq,
    output logic              memWrEn,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata,
    input  logic              memReady,
    output logic              err
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wren_q, wren_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;

    logic              pick_d;
    logic              finish;
    logic [DATA_W-1:0] resp_data;
    logic              timer_clear, timer_en, timer_expired;

    busy_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wren_d      = wren_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        err_d       = 1'b0;
        mem_req_d   = mem_req_q;
        pick_d      = 1'b0;
        finish      = 1'b0;
        resp_data   = '0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ifReq || dReq) begin
                    pick_d      = dReq && (D_PRIORITY || !ifReq);
                    owner_d     = pick_d ? OWNER_D : OWNER_IF;
                    addr_d      = pick_d ? dAddr : ifAddr;
                    wdata_d     = pick_d ? dWdata : '0;
                    wren_d      = pick_d && dWrEn;
                    mem_req_d   = 1'b1;
                    timer_clear = 1'b1;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                timer_en = 1'b1;
                // memReady beats a simultaneous expiry
                if (memReady) begin
                    finish    = 1'b1;
                    resp_data = wren_q ? '0 : memRdata;
                end else if (timer_expired) begin
                    finish    = 1'b1;
                    resp_data = DATA_W'(ABORT_DATA);
                    err_d     = 1'b1;
                end
                if (finish) begin
                    if (owner_q == OWNER_D) begin
                        d_rdata_d = resp_data;
                        d_valid_d = 1'b1;
                    end else begin
                        if_rdata_d = resp_data;
                        if_valid_d = 1'b1;
                    end
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWNER_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            wren_q     <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wren_q     <= wren_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            err_q      <= err_d;
            mem_req_q  <= mem_req_d;
        end
    end

    assign memReq   = mem_req_q;
    assign memWrEn  = wren_q && mem_req_q;
    assign memAddr  = addr_q;
    assign memWdata = wdata_q;
    assign ifValid  = if_valid_q;
    assign ifRdata  = if_rdata_q;
    assign dValid   = d_valid_q;
    assign dRdata   = d_rdata_q;
    assign err      = err_q;

endmodule
